// File: rtl/mem_write_checker.sv
// Watches a CPU store stream against a preloaded table of expected (address, data) writes
// and reports PASS, FAIL or timeout, with hit/match/error/stray statistics.
module mem_write_checker #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int K        = 4,
  parameter int PC_LIMIT = 100,
  parameter int ORDERED  = 1,
  parameter int STRICT   = 1,
  localparam int IW      = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  input  logic          start,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  input  logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [K-1:0]  hit_mask,
  output logic [7:0]    match_count,
  output logic [7:0]    err_count,
  output logic [7:0]    stray_count,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam int            PW     = $clog2(K + 1);
  localparam logic [AW-1:0] PC_LIM = AW'(PC_LIMIT);

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_tab_addr [K];
  logic [DW-1:0] r_tab_data [K];
  logic [PW-1:0] r_ptr;
  logic [K-1:0]  r_hit_mask, w_hit_next;
  logic [7:0]    r_match_count, r_err_count, r_stray_count;
  logic [AW-1:0] r_first_err_addr;
  logic [DW-1:0] r_first_err_data;
  logic          r_busy, r_done, r_pass, r_fail;

  logic          w_store, w_start_run, w_found, w_addr_hit, w_data_ok;
  logic          w_is_match, w_is_err, w_is_stray;
  logic [IW-1:0] w_free_idx, w_sel_idx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: the expectation table is plain storage with no reset; it must be reloaded before start.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && exp_we) begin
      r_tab_addr[exp_idx] <= exp_addr;
      r_tab_data[exp_idx] <= exp_data;
    end
  end

  // Lowest-index unmatched entry whose address equals the store address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (!r_hit_mask[i] && r_tab_addr[i] == dataadr) begin
        w_found    = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_store = (r_state == S_RUN) && memwrite;
    if (ORDERED != 0) begin
      w_sel_idx  = r_ptr[IW-1:0];
      w_addr_hit = (r_tab_addr[w_sel_idx] == dataadr);
    end else begin
      w_sel_idx  = w_free_idx;
      w_addr_hit = w_found;
    end
    w_data_ok  = (r_tab_data[w_sel_idx] == writedata);
    w_is_match = w_store &&  w_addr_hit &&  w_data_ok;
    w_is_err   = w_store &&  w_addr_hit && !w_data_ok;
    w_is_stray = w_store && !w_addr_hit;
    w_hit_next = r_hit_mask | (K'(w_is_match) << w_sel_idx);
  end

  always_comb begin
    w_start_run  = start && (r_state != S_RUN);
    w_next_state = r_state;
    case (r_state)
      S_RUN: begin
        if (STRICT != 0 && w_is_err) w_next_state = S_FAIL;
        else if (&w_hit_next)        w_next_state = S_PASS;
        else if (pc > PC_LIM)        w_next_state = S_FAIL;
      end
      default: if (start) w_next_state = S_RUN;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail           <= 1'b0;
      r_ptr            <= '0;
      r_hit_mask       <= '0;
      r_match_count    <= '0;
      r_err_count      <= '0;
      r_stray_count    <= '0;
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_RUN);
      r_done  <= (w_next_state == S_PASS) || (w_next_state == S_FAIL);
      r_pass  <= (w_next_state == S_PASS);
      r_fail  <= (w_next_state == S_FAIL);
      if (w_start_run) begin
        r_ptr            <= '0;
        r_hit_mask       <= '0;
        r_match_count    <= '0;
        r_err_count      <= '0;
        r_stray_count    <= '0;
        r_first_err_addr <= '0;
        r_first_err_data <= '0;
      end else if (w_store) begin
        r_hit_mask <= w_hit_next;
        if (w_is_match) begin
          r_match_count <= sat_inc(r_match_count);
          if (ORDERED != 0) r_ptr <= r_ptr + PW'(1);
        end
        // A zero error count means this is the first error since start.
        if (w_is_err) begin
          r_err_count <= sat_inc(r_err_count);
          if (r_err_count == 8'd0) begin
            r_first_err_addr <= dataadr;
            r_first_err_data <= writedata;
          end
        end
        if (w_is_stray) r_stray_count <= sat_inc(r_stray_count);
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign hit_mask       = r_hit_mask;
  assign match_count    = r_match_count;
  assign err_count      = r_err_count;
  assign stray_count    = r_stray_count;
  assign first_err_addr = r_first_err_addr;
  assign first_err_data = r_first_err_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: three variants (ordered/strict, any-order/strict, ordered/lenient)
// share one stimulus stream and are compared against a rule-level model every cycle.
module tb_mem_write_checker;

  localparam int DW = 32, AW = 32, K = 2, ND = 3, PCL = 100;
  localparam logic [ND-1:0] CFG_ORD = 3'b101;
  localparam logic [ND-1:0] CFG_STR = 3'b011;

  typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL} mst_t;

  logic          clk = 1'b0, reset = 1'b1;
  logic          exp_we = 1'b0, start = 1'b0, memwrite = 1'b0;
  logic [0:0]    exp_idx = '0;
  logic [AW-1:0] exp_addr = '0, dataadr = '0, pc = '0;
  logic [DW-1:0] exp_data = '0, writedata = '0;

  logic          o_busy [ND], o_done [ND], o_pass [ND], o_fail [ND];
  logic [K-1:0]  o_hit  [ND];
  logic [7:0]    o_mc [ND], o_ec [ND], o_sc [ND];
  logic [AW-1:0] o_fea [ND];
  logic [DW-1:0] o_fed [ND];

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_write_checker #(
      .DW(DW), .AW(AW), .K(K), .PC_LIMIT(PCL),
      .ORDERED(int'(CFG_ORD[g])), .STRICT(int'(CFG_STR[g]))
    ) u_dut (
      .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
      .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .pc(pc),
      .busy(o_busy[g]), .done(o_done[g]), .pass(o_pass[g]), .fail(o_fail[g]),
      .hit_mask(o_hit[g]), .match_count(o_mc[g]), .err_count(o_ec[g]),
      .stray_count(o_sc[g]), .first_err_addr(o_fea[g]), .first_err_data(o_fed[g])
    );
  end

  // Reference model: per-variant table, match flags and counters.
  mst_t          m_st  [ND];
  logic [AW-1:0] m_ta  [ND][K];
  logic [DW-1:0] m_td  [ND][K];
  bit            m_hit [ND][K];
  int            m_mc [ND], m_ec [ND], m_sc [ND];
  bit            m_seen [ND];
  logic [AW-1:0] m_fea [ND];
  logic [DW-1:0] m_fed [ND];

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_clear(input int d);
    for (int i = 0; i < K; i++) m_hit[d][i] = 1'b0;
    m_mc[d] = 0; m_ec[d] = 0; m_sc[d] = 0;
    m_seen[d] = 1'b0; m_fea[d] = '0; m_fed[d] = '0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_st[d] = M_IDLE;
      model_clear(d);
    end
  endtask

  task automatic model_edge();
    int  sel, nxt;
    bit  err_now, all_hit;
    for (int d = 0; d < ND; d++) begin
      sel = -1; nxt = -1; err_now = 1'b0; all_hit = 1'b1;
      case (m_st[d])
        M_IDLE: begin
          if (exp_we) begin
            m_ta[d][exp_idx] = exp_addr;
            m_td[d][exp_idx] = exp_data;
          end
          if (start) begin model_clear(d); m_st[d] = M_RUN; end
        end
        M_PASS, M_FAIL: if (start) begin model_clear(d); m_st[d] = M_RUN; end
        default: begin
          if (memwrite) begin
            if (CFG_ORD[d]) begin
              // In order: only the earliest unmatched entry may be matched next.
              for (int i = K - 1; i >= 0; i--) if (!m_hit[d][i]) nxt = i;
              if (nxt >= 0 && m_ta[d][nxt] == dataadr) sel = nxt;
            end else begin
              for (int i = K - 1; i >= 0; i--)
                if (!m_hit[d][i] && m_ta[d][i] == dataadr) sel = i;
            end
            if (sel < 0) m_sc[d] = sat(m_sc[d] + 1);
            else if (m_td[d][sel] == writedata) begin
              m_hit[d][sel] = 1'b1;
              m_mc[d] = sat(m_mc[d] + 1);
            end else begin
              m_ec[d] = sat(m_ec[d] + 1);
              err_now = 1'b1;
              if (!m_seen[d]) begin
                m_seen[d] = 1'b1; m_fea[d] = dataadr; m_fed[d] = writedata;
              end
            end
          end
          for (int i = 0; i < K; i++) if (!m_hit[d][i]) all_hit = 1'b0;
          if (CFG_STR[d] && err_now) m_st[d] = M_FAIL;
          else if (all_hit)          m_st[d] = M_PASS;
          else if (pc > PCL)         m_st[d] = M_FAIL;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [K-1:0] eh;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < K; i++) eh[i] = m_hit[d][i];
      chk($sformatf("dut%0d.busy", d), 64'(o_busy[d]), 64'(m_st[d] == M_RUN));
      chk($sformatf("dut%0d.done", d), 64'(o_done[d]), 64'(m_st[d] == M_PASS || m_st[d] == M_FAIL));
      chk($sformatf("dut%0d.pass", d), 64'(o_pass[d]), 64'(m_st[d] == M_PASS));
      chk($sformatf("dut%0d.fail", d), 64'(o_fail[d]), 64'(m_st[d] == M_FAIL));
      chk($sformatf("dut%0d.hit_mask", d), 64'(o_hit[d]), 64'(eh));
      chk($sformatf("dut%0d.match_count", d), 64'(o_mc[d]), 64'(m_mc[d]));
      chk($sformatf("dut%0d.err_count", d), 64'(o_ec[d]), 64'(m_ec[d]));
      chk($sformatf("dut%0d.stray_count", d), 64'(o_sc[d]), 64'(m_sc[d]));
      chk($sformatf("dut%0d.first_err_addr", d), 64'(o_fea[d]), 64'(m_fea[d]));
      chk($sformatf("dut%0d.first_err_data", d), 64'(o_fed[d]), 64'(m_fed[d]));
    end
  endtask

  // Inputs change at posedge+1; the model steps on pre-edge inputs, outputs are sampled at posedge+1.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] dv);
    exp_we = 1'b1; exp_idx = idx[0:0]; exp_addr = a; exp_data = dv;
    cycle();
    exp_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] dv, input logic [AW-1:0] pcv);
    memwrite = 1'b1; dataadr = a; writedata = dv; pc = pcv;
    cycle();
    memwrite = 1'b0; pc = '0;
  endtask

  task automatic idle_pc(input logic [AW-1:0] pcv);
    pc = pcv;
    cycle();
    pc = '0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b1;
    cycle();

    // In-order pass with the two-entry table.
    load(0, 32'd1, 32'h0C0C_000A);
    load(1, 32'd63, 32'd0);
    go();
    store(32'd1, 32'h0C0C_000A, 32'd4);
    store(32'd63, 32'd0, 32'd8);
    chk("s1.pass", 64'(o_pass[0]), 64'd1);
    chk("s1.match_count", 64'(o_mc[0]), 64'd2);
    chk("s1.err_count", 64'(o_ec[0]), 64'd0);

    // Reversed order: stray in order-checking variants, pass when any order is allowed.
    go();
    store(32'd63, 32'd0, 32'd4);
    store(32'd1, 32'h0C0C_000A, 32'd8);
    chk("s2.ord_stray", 64'(o_sc[0]), 64'd1);
    chk("s2.ord_pass", 64'(o_pass[0]), 64'd0);
    chk("s2.any_pass", 64'(o_pass[1]), 64'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("s2.start_in_run_ignored", 64'(o_hit[0]), 64'd1);
    idle_pc(32'd101);

    // Data mismatch: strict variants fail at once, the lenient one keeps running.
    go();
    store(32'd1, 32'h0C0C_000B, 32'd4);
    chk("s3.strict_fail", 64'(o_fail[0]), 64'd1);
    chk("s3.first_err_addr", 64'(o_fea[0]), 64'd1);
    chk("s3.first_err_data", 64'(o_fed[0]), 64'h0C0C_000B);
    chk("s3.lenient_err", 64'(o_ec[2]), 64'd1);
    chk("s3.lenient_busy", 64'(o_busy[2]), 64'd1);
    idle_pc(32'd101);

    // Timeout with no stores; pc == limit must not yet time out.
    go();
    for (int p = 95; p <= 101; p++) begin
      idle_pc(AW'(p));
      if (p == 100) chk("s4.busy_at_limit", 64'(o_busy[0]), 64'd1);
    end
    chk("s4.timeout_fail", 64'(o_fail[0]), 64'd1);
    chk("s4.timeout_hit", 64'(o_hit[0]), 64'd0);

    // Table writes outside IDLE are ignored; final match coincides with timeout pc.
    load(0, 32'd77, 32'd5);
    go();
    store(32'd1, 32'h0C0C_000A, 32'd50);
    store(32'd63, 32'd0, 32'd101);
    chk("s5.pass_at_timeout", 64'(o_pass[0]), 64'd1);
    chk("s5.pass_any", 64'(o_pass[1]), 64'd1);
    store(32'd1, 32'h0C0C_000B, 32'd0);
    chk("s5.store_outside_run", 64'(o_ec[0]), 64'd0);

    // Re-store to an already matched address counts as stray.
    go();
    store(32'd1, 32'h0C0C_000A, 32'd0);
    store(32'd1, 32'h0C0C_000A, 32'd0);
    chk("s6.rehit_stray", 64'(o_sc[1]), 64'd1);
    idle_pc(32'd101);

    // Stray counter saturation, then asynchronous abort mid-run.
    go();
    for (int i = 0; i < 300; i++) store(AW'(200 + i), 32'd0, 32'd0);
    chk("s7.stray_sat", 64'(o_sc[0]), 64'd255);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    chk("s7.async_busy", 64'(o_busy[0]), 64'd0);
    chk("s7.async_stray", 64'(o_sc[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cycle();

    // Randomised traffic over a small address/data space.
    load(0, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 3)));
    load(1, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 3)));
    go();
    for (int n = 0; n < 400; n++) begin
      memwrite  = 1'($urandom_range(0, 1));
      dataadr   = AW'($urandom_range(0, 7));
      writedata = DW'($urandom_range(0, 3));
      pc        = ($urandom_range(0, 15) == 0) ? AW'(101 + $urandom_range(0, 5))
                                               : AW'($urandom_range(0, 100));
      start     = ($urandom_range(0, 9) == 0);
      exp_we    = ($urandom_range(0, 9) == 0);
      exp_idx   = 1'($urandom_range(0, 1));
      exp_addr  = AW'($urandom_range(0, 7));
      exp_data  = DW'($urandom_range(0, 3));
      cycle();
    end
    memwrite = 1'b0; start = 1'b0; exp_we = 1'b0; pc = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
